mdu_result_sequencer: RTL and testbench

//  Issue/collect sequencer placed directly downstream of the multiply/divide unit.

---
 rtl/mdu_result_sequencer.sv | 138 +++++++++++++
 tb/tb_mdu_result_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_result_sequencer.sv
// rtl/mdu_result_sequencer.sv - MDU issue/collect sequencer with result holding register
// Optional feature: MDU_DIV_ZERO_BYPASS_EN short-circuits divide-by-zero to 32'hFFFF_FFFF.
module mdu_result_sequencer #(
    parameter int MUL_LATENCY    = 2,
    parameter int DIV_MIN_CYCLES = 2,
    parameter int DIV_MAX_CYCLES = 64
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStart,
    input  logic        iOperation,
    input  logic [31:0] iSrc1,
    input  logic [31:0] iMduResult,
    input  logic        iDivReady,
    input  logic        iRead,
    output logic        oMduOp,
    output logic        oBusy,
    output logic        oStall,
    output logic        oValid,
    output logic [31:0] oResult,
    output logic        oError
);

    localparam int CNT_W = $clog2(DIV_MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_MIN_C = CNT_W'(DIV_MIN_CYCLES);
    localparam logic [CNT_W-1:0] DIV_MAX_C = CNT_W'(DIV_MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_WAIT = 2'd1;
    localparam logic [1:0] S_DIV_WAIT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdu_op_q, mdu_op_d;
    logic             valid_q, valid_d;
    logic [31:0]      result_q, result_d;
    logic             error_q, error_d;

    logic             accept;
    logic             zero_bypass;

`ifdef MDU_DIV_ZERO_BYPASS_EN
    assign zero_bypass = iOperation && (iSrc1 == 32'd0);
`else
    logic unused_src1;
    assign unused_src1 = ^iSrc1;
    assign zero_bypass = 1'b0;
`endif

    // A new request is taken from IDLE, or from DONE when the consumer reads in the same cycle.
    assign accept = iStart && ((state_q == S_IDLE) || ((state_q == S_DONE) && iRead));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdu_op_d = mdu_op_q;
        valid_d  = valid_q;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            S_MUL_WAIT: begin
                cnt_d = (cnt_q == DIV_MAX_C) ? cnt_q : cnt_q + CNT_ONE;
                if (cnt_q == MUL_LAT_C) begin
                    result_d = iMduResult;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DIV_WAIT: begin
                cnt_d = (cnt_q == DIV_MAX_C) ? cnt_q : cnt_q + CNT_ONE;
                // Ready is checked first so a ready arriving on the timeout cycle still wins.
                if (iDivReady && (cnt_q >= DIV_MIN_C)) begin
                    result_d = iMduResult;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == DIV_MAX_C) begin
                    result_d = 32'd0;
                    valid_d  = 1'b1;
                    error_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (iRead) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            mdu_op_d = iOperation;
            cnt_d    = CNT_ONE;
            error_d  = 1'b0;
            valid_d  = 1'b0;
            state_d  = iOperation ? S_DIV_WAIT : S_MUL_WAIT;
            if (zero_bypass) begin
                result_d = 32'hFFFF_FFFF;
                valid_d  = 1'b1;
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mdu_op_q <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mdu_op_q <= mdu_op_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign oMduOp  = mdu_op_q;
    assign oBusy   = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT);
    assign oStall  = oBusy || accept || (valid_q && !iRead);
    assign oValid  = valid_q;
    assign oResult = result_q;
    assign oError  = error_q;

endmodule

// File: tb/tb_mdu_result_sequencer.sv
// tb/tb_mdu_result_sequencer.sv - self-checking bench for mdu_result_sequencer
module tb_mdu_result_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_MIN = 2;
    localparam int DIV_MAX = 8;

`ifdef MDU_DIV_ZERO_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iStart;
    logic        iOperation;
    logic [31:0] iSrc1;
    logic [31:0] iMduResult;
    logic        iDivReady;
    logic        iRead;
    logic        oMduOp;
    logic        oBusy;
    logic        oStall;
    logic        oValid;
    logic [31:0] oResult;
    logic        oError;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] dat [0:DIV_MAX];
    logic        rdy [0:DIV_MAX];

    mdu_result_sequencer #(
        .MUL_LATENCY   (MUL_LAT),
        .DIV_MIN_CYCLES(DIV_MIN),
        .DIV_MAX_CYCLES(DIV_MAX)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iOperation(iOperation),
        .iSrc1     (iSrc1),
        .iMduResult(iMduResult),
        .iDivReady (iDivReady),
        .iRead     (iRead),
        .oMduOp    (oMduOp),
        .oBusy     (oBusy),
        .oStall    (oStall),
        .oValid    (oValid),
        .oResult   (oResult),
        .oError    (oError)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; with_read models the consumer reading on the same edge.
    task automatic accept_req(input logic op, input logic [31:0] src1, input logic with_read);
        iStart     = 1'b1;
        iOperation = op;
        iSrc1      = src1;
        iRead      = with_read;
        #1;
        check("stall_on_accept", oStall, 1);
        tick();
        iStart = 1'b0;
        iRead  = 1'b0;
        check("mdu_op", oMduOp, op);
        check("error_cleared", oError, 0);
    endtask

    // Reference: the result is whatever the MDU bus carries on the edge the request completes.
    task automatic collect(input logic op, input logic [31:0] src1, input logic [15:0] rdy_mask,
                           input int fk, input logic [31:0] fv);
        int          cap;
        logic [31:0] exp_res;
        logic        exp_err;
        for (int k = 1; k <= DIV_MAX; k++) begin
            dat[k] = $urandom;
            rdy[k] = rdy_mask[k];
        end
        if (fk > 0) dat[fk] = fv;
        if (op == 1'b0) begin
            cap     = MUL_LAT;
            exp_res = dat[MUL_LAT];
            exp_err = 1'b0;
        end else begin
            cap     = DIV_MAX;
            exp_res = 32'd0;
            exp_err = 1'b1;
            for (int k = DIV_MAX; k >= DIV_MIN; k--) begin
                if (rdy[k]) begin
                    cap     = k;
                    exp_res = dat[k];
                    exp_err = 1'b0;
                end
            end
        end
        if (BYPASS_EN && op && (src1 == 32'd0)) begin
            cap     = 0;
            exp_res = 32'hFFFF_FFFF;
            exp_err = 1'b0;
        end
        check("valid_k0", oValid, (cap == 0));
        check("busy_k0", oBusy, (cap != 0));
        for (int k = 1; k <= cap; k++) begin
            iMduResult = dat[k];
            iDivReady  = rdy[k];
            tick();
            check("valid_wait", oValid, (k == cap));
            check("busy_wait", oBusy, (k != cap));
        end
        iDivReady = 1'b0;
        check("result", oResult, exp_res);
        check("error", oError, exp_err);
        check("stall_done", oStall, 1);
        iMduResult = $urandom;
        iDivReady  = 1'b1;
        tick();
        iDivReady = 1'b0;
        check("hold_result", oResult, exp_res);
        check("hold_valid", oValid, 1);
    endtask

    task automatic release_result();
        iRead = 1'b1;
        #1;
        check("stall_on_read", oStall, 0);
        tick();
        iRead = 1'b0;
        check("valid_after_read", oValid, 0);
        check("busy_after_read", oBusy, 0);
    endtask

    initial begin
        logic        in_done;
        logic        op;
        logic [31:0] src1;
        iRst_n     = 1'b0;
        iStart     = 1'b0;
        iOperation = 1'b0;
        iSrc1      = 32'd1;
        iMduResult = 32'hDEAD_BEEF;
        iDivReady  = 1'b0;
        iRead      = 1'b0;
        tick();
        tick();
        check("rst_valid", oValid, 0);
        check("rst_result", oResult, 0);
        check("rst_error", oError, 0);
        check("rst_busy", oBusy, 0);
        check("rst_mduop", oMduOp, 0);
        check("rst_stall", oStall, 0);
        iRst_n = 1'b1;
        tick();

        // Multiply with known capture value
        accept_req(1'b0, 32'd3, 1'b0);
        collect(1'b0, 32'd3, 16'h0000, MUL_LAT, 32'h1234_5678);
        release_result();

        // Divide: early ready masked, later ready captured
        accept_req(1'b1, 32'd9, 1'b0);
        collect(1'b1, 32'd9, 16'h0022, 5, 32'h0000_0007);
        release_result();

        // Divide timeout, error sticky until the next accepted start
        accept_req(1'b1, 32'd9, 1'b0);
        collect(1'b1, 32'd9, 16'h0000, 0, 32'd0);
        release_result();
        check("error_sticky", oError, 1);

        // Ready on the timeout cycle wins
        accept_req(1'b1, 32'd4, 1'b0);
        collect(1'b1, 32'd4, 16'h0100, DIV_MAX, 32'hA5A5_0001);

        // Back-to-back multiply from DONE with read
        accept_req(1'b0, 32'd2, 1'b1);
        collect(1'b0, 32'd2, 16'h0000, 0, 32'd0);
        release_result();

        // Divide by zero: bypass when enabled, otherwise a normal divider wait
        accept_req(1'b1, 32'd0, 1'b0);
        collect(1'b1, 32'd0, 16'h0008, 3, 32'h0000_0055);
        release_result();

        // Reset during DIV_WAIT
        accept_req(1'b1, 32'd5, 1'b0);
        tick();
        tick();
        iRst_n = 1'b0;
        tick();
        iRst_n = 1'b1;
        check("midrst_valid", oValid, 0);
        check("midrst_result", oResult, 0);
        check("midrst_error", oError, 0);
        check("midrst_busy", oBusy, 0);
        check("midrst_mduop", oMduOp, 0);
        check("midrst_stall", oStall, 0);
        iDivReady  = 1'b1;
        iMduResult = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("late_ready_no_valid", oValid, 0);
        end
        iDivReady = 1'b0;

        // Randomized transactions
        in_done = 1'b0;
        for (int t = 0; t < 16; t++) begin
            op   = 1'($urandom_range(0, 1));
            src1 = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'd1);
            if (in_done && ($urandom_range(0, 1) == 1)) begin
                accept_req(op, src1, 1'b1);
            end else begin
                if (in_done) release_result();
                accept_req(op, src1, 1'b0);
            end
            collect(op, src1, 16'($urandom), 0, 32'd0);
            in_done = 1'b1;
        end
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
